// File: rtl/kmac_bytepad_ctrl.sv
// Streams bytepad(encode_string(N) || encode_string(S), RATE_BYTES) one byte per cycle over valid/ready.
// Define KMAC_BYTEPAD_ERR_EN to reject over-long lengths with an err pulse instead of clamping them.
module kmac_bytepad_ctrl #(
  parameter int MAX_LEN    = 32,
  parameter int RATE_BYTES = 168,
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*MAX_LEN-1:0] n_bytes,
  input  logic [LW-1:0]        n_len,
  input  logic [8*MAX_LEN-1:0] s_bytes,
  input  logic [LW-1:0]        s_len,
  output logic [7:0]           out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
`ifdef KMAC_BYTEPAD_ERR_EN
  ,
  output logic                 err
`endif
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] RATE8 = 8'(RATE_BYTES);

  typedef enum logic [2:0] {IDLE, W_ENC, N_LEN, N_BODY, S_LEN, S_BODY, PAD, DONE} state_t;

  state_t      state;
  logic [7:0]  pos_cnt;
  logic [7:0]  blk_cnt;
  logic [LW-1:0] n_len_reg;
  logic [LW-1:0] s_len_reg;
  logic [7:0]  n_in  [MAX_LEN];
  logic [7:0]  s_in  [MAX_LEN];
  logic [7:0]  n_mem [MAX_LEN];
  logic [7:0]  s_mem [MAX_LEN];

  logic [LW-1:0] n_len_cl, s_len_cl;
  logic [7:0]  n_len8, s_len8, kn, ks, blk_next;
  logic        accept;
  state_t      nxt_state;
  logic [7:0]  nxt_pos, nxt_byte;
  logic        nxt_last;

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_unpack
    assign n_in[gi] = n_bytes[8*gi +: 8];
    assign s_in[gi] = s_bytes[8*gi +: 8];
  end

  assign n_len_cl = (n_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : n_len;
  assign s_len_cl = (s_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : s_len;

`ifdef KMAC_BYTEPAD_ERR_EN
  logic len_bad;
  assign len_bad = (n_len > LW'(MAX_LEN)) || (s_len > LW'(MAX_LEN));
  assign accept  = start && !len_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= (state == IDLE) && start && len_bad;
  end
`else
  assign accept = start;
`endif

  assign n_len8   = 8'(n_len_reg);
  assign s_len8   = 8'(s_len_reg);
  assign kn       = (n_len8 >= 8'd32) ? 8'd2 : 8'd1;
  assign ks       = (s_len8 >= 8'd32) ? 8'd2 : 8'd1;
  assign blk_next = (blk_cnt == RATE8 - 8'd1) ? 8'd0 : blk_cnt + 8'd1;

  // left_encode(8*len): length byte k, then the bit count big-endian in k bytes
  function automatic logic [7:0] enc_byte(input logic [7:0] len, input logic [7:0] pos);
    logic [10:0] bits;
    bits = {len, 3'b000};
    if (pos == 8'd0) return (len >= 8'd32) ? 8'd2 : 8'd1;
    if (pos == 8'd1 && len >= 8'd32) return {5'd0, bits[10:8]};
    return bits[7:0];
  endfunction

  // Field/position of the byte that follows the one currently presented
  always_comb begin
    nxt_state = state;
    nxt_pos   = pos_cnt + 8'd1;
    case (state)
      W_ENC:  if (pos_cnt == 8'd1) begin nxt_state = N_LEN; nxt_pos = 8'd0; end
      N_LEN:  if (pos_cnt == kn) begin
                if (n_len8 != 8'd0) nxt_state = N_BODY;
                else                nxt_state = S_LEN;
                nxt_pos = 8'd0;
              end
      N_BODY: if (pos_cnt == n_len8 - 8'd1) begin nxt_state = S_LEN; nxt_pos = 8'd0; end
      S_LEN:  if (pos_cnt == ks) begin
                if (s_len8 != 8'd0) nxt_state = S_BODY;
                else                nxt_state = PAD;
                nxt_pos = 8'd0;
              end
      S_BODY: if (pos_cnt == s_len8 - 8'd1) begin nxt_state = PAD; nxt_pos = 8'd0; end
      PAD:    nxt_state = PAD;
      default: nxt_pos = 8'd0;
    endcase

    case (nxt_state)
      W_ENC:   nxt_byte = (nxt_pos == 8'd0) ? 8'h01 : RATE8;
      N_LEN:   nxt_byte = enc_byte(n_len8, nxt_pos);
      N_BODY:  nxt_byte = n_mem[nxt_pos[PW-1:0]];
      S_LEN:   nxt_byte = enc_byte(s_len8, nxt_pos);
      S_BODY:  nxt_byte = s_mem[nxt_pos[PW-1:0]];
      default: nxt_byte = 8'h00;
    endcase

    nxt_last = (blk_next == RATE8 - 8'd1) &&
               ((nxt_state == PAD) ||
                (nxt_state == S_BODY && nxt_pos == s_len8 - 8'd1) ||
                (nxt_state == S_LEN && s_len8 == 8'd0 && nxt_pos == ks));
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      n_mem <= n_in;
      s_mem <= s_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos_cnt   <= 8'd0;
      blk_cnt   <= 8'd0;
      n_len_reg <= '0;
      s_len_reg <= '0;
      out_byte  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          n_len_reg <= n_len_cl;
          s_len_reg <= s_len_cl;
          state     <= W_ENC;
          pos_cnt   <= 8'd0;
          blk_cnt   <= 8'd0;
          out_byte  <= 8'h01;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
          busy      <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: if (out_valid && out_ready) begin
          blk_cnt <= blk_next;
          if (out_last) begin
            state     <= DONE;
            pos_cnt   <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_byte  <= 8'h00;
            done      <= 1'b1;
          end else begin
            state    <= nxt_state;
            pos_cnt  <= nxt_pos;
            out_byte <= nxt_byte;
            out_last <= nxt_last;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmac_bytepad_ctrl.sv
// Bench for kmac_bytepad_ctrl: two instances (rate 168 and rate 8) checked against a queue-style stream model.
`timescale 1ns/1ps
module tb_kmac_bytepad_ctrl;

  localparam int ML   = 32;
  localparam int LW   = $clog2(ML + 1);
  localparam int MAXS = 600;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic            start [2];
  logic [8*ML-1:0] nb [2];
  logic [8*ML-1:0] sb [2];
  logic [LW-1:0]   nl [2];
  logic [LW-1:0]   sl [2];
  logic [7:0]      ob [2];
  logic            ov [2];
  logic            ol [2];
  logic            bz [2];
  logic            dn [2];
`ifdef KMAC_BYTEPAD_ERR_EN
  logic            er [2];
`endif

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  logic [7:0] exp_mem [2][MAXS];
  int         exp_len [2];
  logic [7:0] rx_mem  [2][MAXS];
  int         rx_idx  [2];
  bit         done_exp [2];
  bit         done_seen [2];
  bit         st_pend [2];
  logic [7:0] hold_b [2];
  logic       hold_l [2];

  logic [7:0] t1 [10] = '{8'h01, 8'hA8, 8'h01, 8'h20, 8'h4B, 8'h4D, 8'h41, 8'h43, 8'h01, 8'h00};
  logic [7:0] t2 [8]  = '{8'h01, 8'h08, 8'h01, 8'h00, 8'h01, 8'h10, 8'h61, 8'h62};

  always #5 clk = ~clk;

  kmac_bytepad_ctrl #(.MAX_LEN(ML), .RATE_BYTES(168)) dut (
    .clk(clk), .rst(rst), .start(start[0]),
    .n_bytes(nb[0]), .n_len(nl[0]), .s_bytes(sb[0]), .s_len(sl[0]),
    .out_byte(ob[0]), .out_valid(ov[0]), .out_ready(rdy), .out_last(ol[0]),
    .busy(bz[0]), .done(dn[0])
`ifdef KMAC_BYTEPAD_ERR_EN
    , .err(er[0])
`endif
  );

  kmac_bytepad_ctrl #(.MAX_LEN(ML), .RATE_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .start(start[1]),
    .n_bytes(nb[1]), .n_len(nl[1]), .s_bytes(sb[1]), .s_len(sl[1]),
    .out_byte(ob[1]), .out_valid(ov[1]), .out_ready(rdy), .out_last(ol[1]),
    .busy(bz[1]), .done(dn[1])
`ifdef KMAC_BYTEPAD_ERR_EN
    , .err(er[1])
`endif
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference stream built straight from bytepad/encode_string/left_encode
  task automatic push(input int i, input int b);
    exp_mem[i][exp_len[i]] = 8'(b);
    exp_len[i]++;
  endtask

  task automatic lenc(input int i, input int x);
    if (x < 256) begin push(i, 1); push(i, x); end
    else begin push(i, 2); push(i, x / 256); push(i, x % 256); end
  endtask

  task automatic build(input int i, input int rate, input logic [8*ML-1:0] n, input int nlen,
                       input logic [8*ML-1:0] s, input int slen);
    exp_len[i] = 0;
    lenc(i, rate);
    lenc(i, 8 * nlen);
    for (int k = 0; k < nlen; k++) push(i, int'(n[8*k +: 8]));
    lenc(i, 8 * slen);
    for (int k = 0; k < slen; k++) push(i, int'(s[8*k +: 8]));
    while (exp_len[i] % rate != 0) push(i, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (st_pend[i]) begin
          chk("stall_valid", int'(ov[i]), 1);
          chk("stall_byte", int'(ob[i]), int'(hold_b[i]));
          chk("stall_last", int'(ol[i]), int'(hold_l[i]));
        end
        chk("done", int'(dn[i]), int'(done_exp[i]));
        if (dn[i]) done_seen[i] = 1'b1;
        done_exp[i] = 1'b0;
        chk("busy", int'(bz[i]), int'(ov[i] | dn[i]));
        if (ov[i] && rdy) begin
          if (rx_idx[i] >= exp_len[i]) begin
            chk("byte_count", rx_idx[i] + 1, exp_len[i]);
          end else begin
            chk("byte", int'(ob[i]), int'(exp_mem[i][rx_idx[i]]));
            chk("last", int'(ol[i]), int'(rx_idx[i] == exp_len[i] - 1));
            rx_mem[i][rx_idx[i]] = ob[i];
            rx_idx[i]++;
            if (rx_idx[i] == exp_len[i]) done_exp[i] = 1'b1;
          end
        end
        st_pend[i] = ov[i] && !rdy;
        hold_b[i]  = ob[i];
        hold_l[i]  = ol[i];
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rdy = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic kick(input int i, input logic [8*ML-1:0] n, input int nlen_in,
                      input logic [8*ML-1:0] s, input int slen_in);
    rx_idx[i] = 0;
    done_seen[i] = 1'b0;
    @(negedge clk);
    nb[i] = n; sb[i] = s; nl[i] = LW'(nlen_in); sl[i] = LW'(slen_in);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    nb[i] = ~n; sb[i] = ~s; nl[i] = '0; sl[i] = '0;
  endtask

  task automatic run(input string tag, input int i, input int rate,
                     input logic [8*ML-1:0] n, input int nlen_in, input int nlen_m,
                     input logic [8*ML-1:0] s, input int slen_in, input int slen_m);
    build(i, rate, n, nlen_m, s, slen_m);
    kick(i, n, nlen_in, s, slen_in);
    for (int c = 0; c < 3000 && !done_seen[i]; c++) @(negedge clk);
    chk({tag, "_finished"}, int'(done_seen[i]), 1);
    chk({tag, "_length"}, rx_idx[i], exp_len[i]);
    $display("stream %s: inst %0d rate %0d received %0d bytes", tag, i, rate, rx_idx[i]);
    repeat (2) @(negedge clk);
  endtask

  logic [8*ML-1:0] n_kmac, n_full, s_ab, s_full, zero_v;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; nb[i] = '0; sb[i] = '0; nl[i] = '0; sl[i] = '0;
      exp_len[i] = 0; rx_idx[i] = 0; done_exp[i] = 1'b0; done_seen[i] = 1'b0;
      st_pend[i] = 1'b0; hold_b[i] = 8'h00; hold_l[i] = 1'b0;
    end
    zero_v = '0;
    n_kmac = '0; n_kmac[31:0] = 32'h43414D4B;
    s_ab   = '0; s_ab[15:0]   = 16'h6261;
    for (int k = 0; k < ML; k++) begin
      n_full[8*k +: 8] = 8'(k + 1);
      s_full[8*k +: 8] = 8'(8'hA0 + k);
    end

    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("reset_byte", int'(ob[i]), 0);
      chk("reset_valid", int'(ov[i]), 0);
      chk("reset_last", int'(ol[i]), 0);
      chk("reset_busy", int'(bz[i]), 0);
      chk("reset_done", int'(dn[i]), 0);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Case 1: N="KMAC", S empty, rate 168
    run("kmac", 0, 168, n_kmac, 4, 4, zero_v, 0, 0);
    for (int k = 0; k < 10; k++) chk("t1_header", int'(rx_mem[0][k]), int'(t1[k]));
    chk("t1_pad_tail", int'(rx_mem[0][167]), 0);
    chk("t1_len", rx_idx[0], 168);

    // Case 2: N empty, S="ab", rate 8, no padding
    run("ab_rate8", 1, 8, zero_v, 0, 0, s_ab, 2, 2);
    for (int k = 0; k < 8; k++) chk("t2_stream", int'(rx_mem[1][k]), int'(t2[k]));
    chk("t2_len", rx_idx[1], 8);

    // Case 3: both strings at maximum length, two-byte length encodings
    run("max", 0, 168, n_full, 32, 32, s_full, 32, 32);
    chk("t3_nlen0", int'(rx_mem[0][2]), 8'h02);
    chk("t3_nlen1", int'(rx_mem[0][3]), 8'h01);
    chk("t3_nlen2", int'(rx_mem[0][4]), 8'h00);
    chk("t3_slen0", int'(rx_mem[0][37]), 8'h02);
    chk("t3_slen2", int'(rx_mem[0][39]), 8'h00);
    chk("t3_s_last", int'(rx_mem[0][71]), 8'hBF);
    chk("t3_pad0", int'(rx_mem[0][72]), 8'h00);

    // Case 4: case 1 under random backpressure
    rdy_mode = 1;
    run("kmac_stall", 0, 168, n_kmac, 4, 4, zero_v, 0, 0);
    for (int k = 0; k < 10; k++) chk("t4_header", int'(rx_mem[0][k]), int'(t1[k]));
    rdy_mode = 0;

    // Case 5: reset in the middle of case 1, then a clean restart
    build(0, 168, n_kmac, 4, zero_v, 0);
    kick(0, n_kmac, 4, zero_v, 0);
    for (int c = 0; c < 100 && rx_idx[0] < 5; c++) @(negedge clk);
    chk("rst_reached_byte5", rx_idx[0], 5);
    #1 rst = 1'b1;
    #1;
    chk("abort_valid", int'(ov[0]), 0);
    chk("abort_byte", int'(ob[0]), 0);
    chk("abort_last", int'(ol[0]), 0);
    chk("abort_busy", int'(bz[0]), 0);
    chk("abort_done", int'(dn[0]), 0);
    rx_idx[0] = 0; exp_len[0] = 0; st_pend[0] = 1'b0; done_exp[0] = 1'b0; done_seen[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_done", int'(done_seen[0]), 0);
    run("kmac_after_rst", 0, 168, n_kmac, 4, 4, zero_v, 0, 0);
    for (int k = 0; k < 10; k++) chk("t5_header", int'(rx_mem[0][k]), int'(t1[k]));

    // Case 6: s_len one beyond MAX_LEN
`ifdef KMAC_BYTEPAD_ERR_EN
    exp_len[0] = 0;
    kick(0, n_kmac, 4, s_full, 33);
    chk("err_pulse", int'(er[0]), 1);
    chk("err_busy", int'(bz[0]), 0);
    chk("err_valid", int'(ov[0]), 0);
    @(negedge clk);
    chk("err_clear", int'(er[0]), 0);
    repeat (6) @(negedge clk);
    chk("err_no_bytes", rx_idx[0], 0);
    chk("err_no_done", int'(done_seen[0]), 0);
`else
    run("clamp", 0, 168, n_kmac, 4, 4, s_full, 33, 32);
    chk("t6_slen0", int'(rx_mem[0][8]), 8'h02);
    chk("t6_slen1", int'(rx_mem[0][9]), 8'h01);
    chk("t6_slen2", int'(rx_mem[0][10]), 8'h00);
    chk("t6_s_last", int'(rx_mem[0][42]), 8'hBF);
    chk("t6_pad0", int'(rx_mem[0][43]), 8'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
